// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the integer register file: default data width and
// register count, the derived address width, and the INIT/RUN state type
// used by the init sequencer.
//
// Optional feature macro used by reg_file: REGFILE_BYPASS_EN (write-to-read
// forwarding). Nothing in this package depends on it.
// ---------------------------------------------------------------------------
package regfile_pkg;

  // Default data width of every register and port.
  localparam int XLEN_DEF  = 32;

  // Default number of architectural registers, including hardwired-zero x0.
  localparam int NREGS_DEF = 32;

  // Address width for the default register count.
  localparam int ADDR_W    = $clog2(NREGS_DEF);

  // Sequencer state: INIT while the clearing sweep runs, RUN afterwards.
  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_init_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_init_ctrl
// Init sequencer for reg_file. After reset it walks a counter from register 1
// up to register NREGS-1, requesting one zero-write per clock, then moves to
// RUN and stays there until the next reset. x0 is never swept because it is
// hardwired to zero at the read ports.
//
// Ports:
//   clk        in   core clock, rising edge
//   rst        in   asynchronous active-high reset (forces INIT, cnt=1)
//   busy       out  high in INIT (which includes the whole time rst is high)
//   init_we    out  sweep write request to the storage write port
//   init_addr  out  register being cleared by the sweep this cycle
// ---------------------------------------------------------------------------
module regfile_init_ctrl
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  output logic                     init_we,
  output logic [$clog2(NREGS)-1:0] init_addr
);

  localparam int RF_AW = $clog2(NREGS);

  // Last register the sweep has to clear.
  localparam logic [RF_AW-1:0] LAST_ADDR  = RF_AW'(NREGS - 1);
  // The sweep starts at x1; x0 needs no storage clear.
  localparam logic [RF_AW-1:0] FIRST_ADDR = RF_AW'(1);

  rf_state_e          r_state;
  logic [RF_AW-1:0]   r_cnt;

  // State register and sweep counter; reset restarts the sweep at x1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RF_INIT;
      r_cnt   <= FIRST_ADDR;
    end else begin
      case (r_state)
        RF_INIT: begin
          if (r_cnt == LAST_ADDR) begin
            // This edge clears the final register; hand over to the core.
            r_state <= RF_RUN;
            r_cnt   <= FIRST_ADDR;
          end else begin
            r_state <= RF_INIT;
            r_cnt   <= r_cnt + RF_AW'(1);
          end
        end
        RF_RUN: begin
          r_state <= RF_RUN;
          r_cnt   <= r_cnt;
        end
        default: begin
          r_state <= RF_INIT;
          r_cnt   <= FIRST_ADDR;
        end
      endcase
    end
  end

  // Decode the sweep outputs from the current state.
  always_comb begin
    busy      = 1'b1;
    init_we   = 1'b0;
    init_addr = r_cnt;
    case (r_state)
      RF_INIT: begin
        busy    = 1'b1;
        init_we = 1'b1;
      end
      RF_RUN: begin
        busy    = 1'b0;
        init_we = 1'b0;
      end
      default: begin
        busy    = 1'b1;
        init_we = 1'b0;
      end
    endcase
  end

endmodule : regfile_init_ctrl

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// Integer register file feeding the ALU: two combinational read ports
// (operand A on rd1, register operand B on rd2) and one clocked write port
// for the writeback result. x0 reads as zero and ignores writes. After reset
// a sweep clears x1..x(NREGS-1) one per cycle while busy is high; during that
// time reads return zero and core writes are dropped.
//
// Ports:
//   clk   in   core clock, rising edge
//   rst   in   asynchronous active-high reset
//   a1    in   read address, port 1
//   a2    in   read address, port 2
//   a3    in   write address
//   we3   in   write enable
//   wd3   in   write data
//   rd1   out  read data port 1, combinational from a1 and state
//   rd2   out  read data port 2, combinational from a2 and state
//   busy  out  high during reset and the init sweep; fetch must stall
//
// Build option: define REGFILE_BYPASS_EN to forward wd3 to a read port whose
// address matches an active write (a3 != 0) in the same cycle.
// ---------------------------------------------------------------------------
module reg_file
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] a1,
  input  logic [$clog2(NREGS)-1:0] a2,
  input  logic [$clog2(NREGS)-1:0] a3,
  input  logic                     we3,
  input  logic [XLEN-1:0]          wd3,
  output logic [XLEN-1:0]          rd1,
  output logic [XLEN-1:0]          rd2,
  output logic                     busy
);

  localparam int RF_AW = $clog2(NREGS);
  localparam logic [RF_AW-1:0] ZERO_ADDR = RF_AW'(0);

  // Storage; entry 0 is never written and never read out (x0 is forced).
  logic [XLEN-1:0]  r_mem [NREGS];

  logic             w_busy;
  logic             w_init_we;
  logic [RF_AW-1:0] w_init_addr;

  logic             w_wr_en;
  logic [RF_AW-1:0] w_wr_addr;
  logic [XLEN-1:0]  w_wr_data;

  regfile_init_ctrl #(
    .NREGS     (NREGS)
  ) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .busy      (w_busy),
    .init_we   (w_init_we),
    .init_addr (w_init_addr)
  );

  assign busy = w_busy;

  // Write-port mux: the sweep owns the port in INIT, the core in RUN.
  // Nothing is written on an edge that sees rst, so a write racing a
  // mid-run reset is dropped.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = ZERO_ADDR;
    w_wr_data = {XLEN{1'b0}};
    if (rst) begin
      w_wr_en = 1'b0;
    end else if (w_busy) begin
      w_wr_en   = w_init_we;
      w_wr_addr = w_init_addr;
      w_wr_data = {XLEN{1'b0}};
    end else begin
      w_wr_en   = we3 && (a3 != ZERO_ADDR);
      w_wr_addr = a3;
      w_wr_data = wd3;
    end
  end

  // Storage array update; contents are cleared by the sweep, not by rst.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_byp1;
  logic w_byp2;

  // Same-cycle forwarding matches; only real writes (a3 != 0) forward.
  always_comb begin
    w_byp1 = 1'b0;
    w_byp2 = 1'b0;
    if (we3 && (a3 != ZERO_ADDR)) begin
      w_byp1 = (a1 == a3);
      w_byp2 = (a2 == a3);
    end else begin
      w_byp1 = 1'b0;
      w_byp2 = 1'b0;
    end
  end
`endif

  // Read port 1: INIT and x0 forcing take priority over any forwarding.
  always_comb begin
    rd1 = {XLEN{1'b0}};
    if (w_busy) begin
      rd1 = {XLEN{1'b0}};
    end else if (a1 == ZERO_ADDR) begin
      rd1 = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (w_byp1) begin
      rd1 = wd3;
`endif
    end else begin
      rd1 = r_mem[a1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd2 = {XLEN{1'b0}};
    if (w_busy) begin
      rd2 = {XLEN{1'b0}};
    end else if (a2 == ZERO_ADDR) begin
      rd2 = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (w_byp2) begin
      rd2 = wd3;
`endif
    end else begin
      rd2 = r_mem[a2];
    end
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
// Self-checking bench for reg_file at default parameters. Inputs change 1ns
// after a rising edge; outputs are sampled 1ns later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  a3;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs[8];

  reg_file dut (
    .clk  (clk),
    .rst  (rst),
    .a1   (a1),
    .a2   (a2),
    .a3   (a3),
    .we3  (we3),
    .wd3  (wd3),
    .rd1  (rd1),
    .rd2  (rd2),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_item_t it;
    it.name = name;
    it.exp  = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop_check(input logic [31:0] act);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
    end else begin
      it = sb_q.pop_front();
      check(it.name, act, it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until busy drops; optionally inject a write on sweep edge 10.
  task automatic run_sweep(input bit inject);
    int n;
    n = 0;
    while (busy && n < 100) begin
      if (inject && n == 9) begin
        we3 = 1'b1;
        a3  = 5'd3;
        wd3 = 32'hA5A5A5A5;
      end
      tick();
      n++;
      we3 = 1'b0;
      a3  = 5'd0;
      wd3 = 32'h0;
      if (n == 1) begin
        a1 = 5'd5;
        a2 = 5'd31;
        #1;
        check("init_rd1_forced", rd1, 32'h0);
        check("init_rd2_forced", rd2, 32'h0);
        check("init_busy", {31'b0, busy}, 32'h1);
      end
    end
    check("sweep_len", n, 32'd31);
  endtask

  initial begin
    logic [31:0] exp_same;

    vecs[0] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h00000000, 32'h12345678};
    vecs[2] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h00000000};
    vecs[3] = '{1'b0, 5'd5,  32'h00000000, 5'd3,  5'd10, 32'h00000000, 32'h00000000};
    vecs[4] = '{1'b1, 5'd31, 32'h55AA55AA, 5'd31, 5'd5,  32'h55AA55AA, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 5'd9,  32'h00000001, 5'd9,  5'd7,  32'h00000001, 32'h12345678};
    vecs[6] = '{1'b0, 5'd0,  32'h00000000, 5'd1,  5'd2,  32'h00000000, 32'h00000000};
    vecs[7] = '{1'b1, 5'd1,  32'h80000001, 5'd1,  5'd31, 32'h80000001, 32'h55AA55AA};

    rst = 1'b1;
    a1  = 5'd5;
    a2  = 5'd7;
    a3  = 5'd0;
    we3 = 1'b0;
    wd3 = 32'h0;

    // Reset state.
    tick();
    tick();
    check("reset_busy", {31'b0, busy}, 32'h1);
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);

    // First sweep, with a write attempted on sweep edge 10.
    rst = 1'b0;
    run_sweep(1'b1);
    check("run_busy_low", {31'b0, busy}, 32'h0);

    // Table-driven writes and reads through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      we3 = vecs[i].we;
      a3  = vecs[i].wa;
      wd3 = vecs[i].wd;
      a1  = vecs[i].ra1;
      a2  = vecs[i].ra2;
      sb_push($sformatf("vec%0d_rd1", i), vecs[i].exp1);
      sb_push($sformatf("vec%0d_rd2", i), vecs[i].exp2);
      tick();
      we3 = 1'b0;
      #1;
      sb_pop_check(rd1);
      sb_pop_check(rd2);
    end
    check("sb_empty", sb_q.size(), 32'd0);

    // Same-cycle read and write of x9 (holds 0x1).
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h00000002;
`else
    exp_same = 32'h00000001;
`endif
    we3 = 1'b1;
    a3  = 5'd9;
    wd3 = 32'h00000002;
    a1  = 5'd9;
    a2  = 5'd9;
    #2;
    check("same_cycle_rd1", rd1, exp_same);
    check("same_cycle_rd2", rd2, exp_same);
    tick();
    we3 = 1'b0;
    #1;
    check("after_edge_rd1", rd1, 32'h00000002);

    // Mid-run reset coincident with a write to x4.
    we3 = 1'b1;
    a3  = 5'd4;
    wd3 = 32'hCAFEF00D;
    a1  = 5'd31;
    rst = 1'b1;
    #1;
    check("midrst_busy_async", {31'b0, busy}, 32'h1);
    check("midrst_rd1_forced", rd1, 32'h0);
    tick();
    rst = 1'b0;
    we3 = 1'b0;
    a3  = 5'd0;
    wd3 = 32'h0;
    run_sweep(1'b0);

    a1 = 5'd4;
    a2 = 5'd31;
    #1;
    check("midrst_x4", rd1, 32'h0);
    check("midrst_x31", rd2, 32'h0);
    a1 = 5'd5;
    a2 = 5'd7;
    #1;
    check("sweep_x5", rd1, 32'h0);
    check("sweep_x7", rd2, 32'h0);

    // A normal write still works after re-init.
    we3 = 1'b1;
    a3  = 5'd12;
    wd3 = 32'h0BADF00D;
    tick();
    we3 = 1'b0;
    a1  = 5'd12;
    #1;
    check("post_reinit_write", rd1, 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_file
